// File: rtl/intr_ctrl.sv
// intr_ctrl: NR_SRC-line interrupt controller on the UIBI slave bus with fixed-priority claim/complete.
// Optional macro INTR_CTRL_LEVEL_EN: sources are level-sensitive instead of rising-edge captured.
module intr_ctrl #(
    parameter int NR_SRC = 4,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NR_SRC-1:0] src_i,
    output logic              irq_o,
    input  logic              bus_req,
    input  logic              bus_wen,
    input  logic [XLEN-1:0]   bus_addr,
    input  logic [1:0]        bus_mode,
    input  logic [XLEN-1:0]   bus_dat_i,
    output logic [XLEN-1:0]   bus_dat_o,
    output logic              bus_ready
);
    localparam logic [1:0] MODE_WORD   = 2'b10;
    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_CLAIM   = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [NR_SRC-1:0] pending_r;
    logic [NR_SRC-1:0] enable_r;
    logic [NR_SRC-1:0] src_d_r;
    logic [4:0]        in_service_id_r;
    logic              irq_r;
    logic [XLEN-1:0]   dat_r;

    logic              rd_s;
    logic              wr_s;
    logic [1:0]        sel_s;
    logic              any_s;
    logic [4:0]        win_id_s;
    logic [NR_SRC-1:0] win_mask_s;
    logic              claim_hit_s;
    logic              complete_hit_s;
    logic [NR_SRC-1:0] w1c_s;
    logic [NR_SRC-1:0] pending_next_s;
    logic [XLEN-1:0]   rdata_s;
    logic              unused_s;

    assign rd_s  = bus_req && !bus_wen && (bus_mode == MODE_WORD);
    assign wr_s  = bus_req && bus_wen && (bus_mode == MODE_WORD);
    assign sel_s = bus_addr[3:2];

    assign claim_hit_s    = rd_s && (sel_s == REG_CLAIM) && (state_r == ST_IDLE) && any_s;
    assign complete_hit_s = wr_s && (sel_s == REG_CLAIM) && (state_r == ST_SERVICE)
                            && (bus_dat_i[4:0] == in_service_id_r);
    assign w1c_s          = (wr_s && (sel_s == REG_PENDING)) ? bus_dat_i[NR_SRC-1:0] : '0;

    // Lowest-index enabled pending source wins the claim.
    always_comb begin
        any_s      = 1'b0;
        win_id_s   = 5'd0;
        win_mask_s = '0;
        for (int i = 0; i < NR_SRC; i++) begin
            if (!any_s && pending_r[i] && enable_r[i]) begin
                any_s         = 1'b1;
                win_id_s      = 5'(i + 1);
                win_mask_s[i] = 1'b1;
            end else begin
                any_s = any_s;
            end
        end
    end

`ifdef INTR_CTRL_LEVEL_EN
    // Level mode: pending simply mirrors the request lines.
    always_comb begin
        pending_next_s = src_i;
    end

    assign unused_s = ^{bus_addr, bus_dat_i, src_d_r, w1c_s, win_mask_s};
`else
    // Edge mode: a rise on the same cycle as a clear keeps the bit set.
    always_comb begin
        pending_next_s = (pending_r & ~(w1c_s | (claim_hit_s ? win_mask_s : '0)))
                         | (src_i & ~src_d_r);
    end

    assign unused_s = ^{bus_addr, bus_dat_i};
`endif

    // Claim/complete state transitions.
    always_comb begin
        case (state_r)
            ST_IDLE:    state_next_s = claim_hit_s ? ST_SERVICE : ST_IDLE;
            ST_SERVICE: state_next_s = complete_hit_s ? ST_IDLE : ST_SERVICE;
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // Register read multiplexer; anything but a decoded word read returns zero.
    always_comb begin
        case (sel_s)
            REG_PENDING: rdata_s = XLEN'(pending_r);
            REG_ENABLE:  rdata_s = XLEN'(enable_r);
            REG_CLAIM:   rdata_s = claim_hit_s ? XLEN'(win_id_s) : '0;
            REG_STATUS:  rdata_s = XLEN'({in_service_id_r, state_r == ST_SERVICE});
            default:     rdata_s = '0;
        endcase
        if (!rd_s) begin
            rdata_s = '0;
        end else begin
            rdata_s = rdata_s;
        end
    end

    // All state and registered outputs; irq looks at the next state so claim/complete act in one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r         <= ST_IDLE;
            pending_r       <= '0;
            enable_r        <= '0;
            src_d_r         <= '0;
            in_service_id_r <= 5'd0;
            irq_r           <= 1'b0;
            dat_r           <= '0;
        end else begin
            state_r   <= state_next_s;
            pending_r <= pending_next_s;
            src_d_r   <= src_i;
            dat_r     <= rdata_s;
            irq_r     <= (state_next_s == ST_IDLE) && (|(pending_r & enable_r));
            if (wr_s && (sel_s == REG_ENABLE)) begin
                enable_r <= bus_dat_i[NR_SRC-1:0];
            end else begin
                enable_r <= enable_r;
            end
            if (claim_hit_s) begin
                in_service_id_r <= win_id_s;
            end else if (complete_hit_s) begin
                in_service_id_r <= 5'd0;
            end else begin
                in_service_id_r <= in_service_id_r;
            end
        end
    end

    assign irq_o     = irq_r;
    assign bus_dat_o = dat_r;
    assign bus_ready = 1'b1;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: read results go through an expected-value queue.
// Edge-capture sequence by default; a level-mode sequence when INTR_CTRL_LEVEL_EN is defined.
module tb_intr_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src_i;
    logic        irq_o;
    logic        bus_req;
    logic        bus_wen;
    logic [31:0] bus_addr;
    logic [1:0]  bus_mode;
    logic [31:0] bus_dat_i;
    logic [31:0] bus_dat_o;
    logic        bus_ready;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    intr_ctrl #(.NR_SRC(4), .XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_i     (src_i),
        .irq_o     (irq_o),
        .bus_req   (bus_req),
        .bus_wen   (bus_wen),
        .bus_addr  (bus_addr),
        .bus_mode  (bus_mode),
        .bus_dat_i (bus_dat_i),
        .bus_dat_o (bus_dat_o),
        .bus_ready (bus_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock; any read issued in the cycle just ended is scored now.
    task automatic tick();
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            check_eq(tag_q.pop_front(), bus_dat_o, exp_q.pop_front());
        end
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        bus_req  = 1'b1;
        bus_wen  = 1'b0;
        bus_addr = addr;
        bus_mode = 2'b10;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick();
        bus_req  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] mode);
        bus_req   = 1'b1;
        bus_wen   = 1'b1;
        bus_addr  = addr;
        bus_mode  = mode;
        bus_dat_i = data;
        tick();
        bus_req   = 1'b0;
        bus_wen   = 1'b0;
        bus_mode  = 2'b10;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; src_i = 4'h0; bus_req = 1'b0; bus_wen = 1'b0;
        bus_addr = 32'h0; bus_mode = 2'b10; bus_dat_i = 32'h0;
        tick();
        tick();
        check_eq("rst_irq", 32'(irq_o), 32'h0);
        check_eq("rst_dat", bus_dat_o, 32'h0);
        check_eq("ready", 32'(bus_ready), 32'h1);
        rst = 1'b1;
        rd(32'h0, 32'h0, "rst_pending");
        rd(32'h4, 32'h0, "rst_enable");
        rd(32'h8, 32'h0, "rst_claim");
        rd(32'hC, 32'h0, "rst_status");
        check_eq("rst_irq2", 32'(irq_o), 32'h0);
`ifdef INTR_CTRL_LEVEL_EN
        wr(32'h4, 32'h4, 2'b10);
        src_i = 4'h4;
        tick();
        rd(32'h0, 32'h4, "lvl_pend");
        wr(32'h0, 32'h4, 2'b10);
        rd(32'h0, 32'h4, "lvl_w1c");
        rd(32'h8, 32'h3, "lvl_claim");
        rd(32'h0, 32'h4, "lvl_after_claim");
        rd(32'hC, 32'h7, "lvl_status");
        check_eq("lvl_irq_svc", 32'(irq_o), 32'h0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        src_i = 4'h0;
        check_eq("lvl_rst_irq", 32'(irq_o), 32'h0);
        rd(32'hC, 32'h0, "lvl_rst_status");
        rd(32'h4, 32'h0, "lvl_rst_enable");
        rd(32'h0, 32'h0, "lvl_fall");
`else
        // Single timer request through claim.
        wr(32'h4, 32'h1, 2'b10);
        src_i = 4'h1;
        tick();
        check_eq("irq_n1", 32'(irq_o), 32'h0);
        tick();
        check_eq("irq_n2", 32'(irq_o), 32'h1);
        tick();
        src_i = 4'h0;
        rd(32'h0, 32'h1, "pend_a");
        check_eq("idle_dat", bus_dat_o, 32'h1);
        tick();
        check_eq("idle_dat0", bus_dat_o, 32'h0);
        rd(32'h8, 32'h1, "claim_a");
        check_eq("irq_fall", 32'(irq_o), 32'h0);
        rd(32'h0, 32'h0, "pend_clr");
        rd(32'hC, 32'h3, "status_a");

        // Activity while in service.
        wr(32'h4, 32'h5, 2'b10);
        src_i = 4'h4;
        tick();
        tick();
        src_i = 4'h0;
        check_eq("irq_svc", 32'(irq_o), 32'h0);
        rd(32'h8, 32'h0, "claim_svc");
        check_eq("irq_svc2", 32'(irq_o), 32'h0);
        wr(32'h8, 32'h2, 2'b10);
        rd(32'hC, 32'h3, "status_keep");
        check_eq("irq_bad_id", 32'(irq_o), 32'h0);
        wr(32'h8, 32'h1, 2'b10);
        check_eq("irq_rise", 32'(irq_o), 32'h1);
        rd(32'h8, 32'h3, "claim_b");
        wr(32'h8, 32'h3, 2'b10);

        // Two simultaneous rises, fixed priority.
        wr(32'h4, 32'hF, 2'b10);
        src_i = 4'hA;
        tick();
        src_i = 4'h0;
        rd(32'h8, 32'h2, "claim_c1");
        wr(32'h8, 32'h2, 2'b10);
        rd(32'h8, 32'h4, "claim_c2");
        wr(32'h8, 32'h4, 2'b10);
        rd(32'h0, 32'h0, "pend_c");

        // Set beats clear, capture while disabled, late enable.
        wr(32'h4, 32'h0, 2'b10);
        src_i = 4'h2;
        wr(32'h0, 32'h2, 2'b10);
        src_i = 4'h0;
        rd(32'h0, 32'h2, "set_wins");
        check_eq("irq_dis", 32'(irq_o), 32'h0);
        wr(32'h4, 32'h2, 2'b10);
        check_eq("en_n1", 32'(irq_o), 32'h0);
        tick();
        check_eq("en_n2", 32'(irq_o), 32'h1);
        wr(32'h0, 32'h2, 2'b10);
        rd(32'h0, 32'h0, "w1c");
        wr(32'h4, 32'h0, 2'b00);
        rd(32'h4, 32'h2, "subword");

        // A held line captures once.
        src_i = 4'h8;
        tick();
        tick();
        wr(32'h0, 32'h8, 2'b10);
        tick();
        tick();
        rd(32'h0, 32'h0, "held_once");
        src_i = 4'h0;
        tick();

        // Reset while in service with bit 2 pending.
        wr(32'h4, 32'hF, 2'b10);
        src_i = 4'h1;
        tick();
        src_i = 4'h0;
        rd(32'h8, 32'h1, "claim_e");
        src_i = 4'h4;
        tick();
        src_i = 4'h0;
        rd(32'h0, 32'h4, "pend_e");
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_eq("rst_svc_irq", 32'(irq_o), 32'h0);
        rd(32'h0, 32'h0, "rst_svc_pending");
        rd(32'h4, 32'h0, "rst_svc_enable");
        rd(32'hC, 32'h0, "rst_svc_status");
        rd(32'h8, 32'h0, "rst_svc_claim");
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt controller that sits directly downstream of the system timer and the other peripheral interrupt lines. It is a UIBI bus slave. It latches rising edges on up to NR_SRC request lines into a pending register, masks them with an enable register and drives a single interrupt line to the CPU. Software services requests through a claim/complete register pair with fixed priority (lowest index wins). Source 0 is wired to the timer `intr` output.

## Interface
- NR_SRC, 4 — number of interrupt sources, 1..31.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- src_i  in  NR_SRC  interrupt request lines, synchronous to clk; bit 0 = timer.
- irq_o  out  1  interrupt to CPU, registered.
- bus_req  in  1  slave access strobe.
- bus_wen  in  1  write enable.
- bus_addr  in  XLEN  byte address; bits [3:2] select the register.
- bus_mode  in  2  access size; only word accesses are decoded, sub-word writes are ignored.
- bus_dat_i  in  XLEN  write data.
- bus_dat_o  out  XLEN  read data, registered.
- bus_ready  out  1  tied to 1.

## Operation
- Register map, addressed by bus_addr[3:2]:
  - 0x0 PENDING: read-only view; writing 1 to a bit clears that bit.
  - 0x4 ENABLE: read/write; bits above NR_SRC-1 read as 0.
  - 0x8 CLAIM: read = claim, write = complete.
  - 0xC STATUS: read-only; bit 0 = in_service, bits [5:1] = in_service_id.
- Edge capture:
  - src_d is the prior-cycle copy of src_i.
  - A rise (src_i & ~src_d) sets the pending bit.
  - Pending bits are captured regardless of ENABLE.
- State machine:
  - IDLE: irq_o = |(pending & enable).
  - IDLE to SERVICE on a claim read when at least one enabled source is pending.
  - In SERVICE, irq_o = 0.
  - SERVICE to IDLE on a CLAIM write whose bus_dat_i[4:0] equals in_service_id.
  - A write with a mismatched id is ignored.
- Claim read in IDLE:
  - Returns k+1, where k is the lowest index with pending & enable.
  - Clears pending[k] and latches in_service_id = k+1.
  - If no enabled source is pending, it returns 0 and the state does not change.
- Claim read in SERVICE returns 0 and has no side effect.
- Reads of PENDING, ENABLE and STATUS have no side effects. Undecoded reads return 0.
- Collision rules:
  - If a set and a clear of the same pending bit (write-1-clear or claim) hit the same cycle, the set wins.
  - A clear of one bit never affects other bits.

## Timing
- Reset values:
  - pending = 0, enable = 0, src_d = 0.
  - state = IDLE, in_service_id = 0.
  - irq_o = 0, bus_dat_o = 0.
- src_i rise at cycle N: pending visible at N+1; irq_o high at N+2 if the source is enabled.
- bus_dat_o is valid one cycle after the bus_req cycle. It is 0 on every cycle without bus_req.
- Claim side effects (pending clear, entry into SERVICE) take effect at the edge that samples the read. irq_o drops on the following cycle.
- ENABLE write at cycle N affects irq_o at N+2.
- A source held high sets pending only once; it must fall and rise again to set pending again.
- Reset asserted in SERVICE returns the block to IDLE with all state cleared on the next edge.

## Configuration
- INTR_CTRL_LEVEL_EN:
  - Defined: sources are level-sensitive. Each cycle, pending is loaded with src_i, and write-1-clear has no effect. A claim read still returns the id and enters SERVICE, but pending stays set while the line stays high.
  - Undefined: edge capture as described above.

## Test plan
- Reset, then read all four registers -> every read returns 0; irq_o = 0.
- Write ENABLE = 0x1, pulse src_i[0] for 3 cycles -> PENDING = 0x1; irq_o rises 2 cycles after the rise; CLAIM read returns 1; irq_o falls; PENDING = 0; STATUS = 0x3.
- While in SERVICE:
  - Pulse src_i[2] with ENABLE = 0x5 -> CLAIM read returns 0; irq_o stays 0.
  - Write CLAIM = 2 -> ignored; STATUS unchanged.
  - Write CLAIM = 1 -> irq_o rises next cycle; the next CLAIM read returns 3.
- Raise src_i[1] and src_i[3] in the same cycle with ENABLE = 0xF -> CLAIM reads return 2, then 4 after completing id 2.
- Same cycle: rise on src_i[1] and write PENDING = 0x2 -> PENDING reads 0x2. With ENABLE = 0 a rise still sets pending and irq_o stays 0; a later ENABLE = 0x2 raises irq_o.
- Assert rst for one cycle while in SERVICE with pending = 0x4 -> all registers read 0; state IDLE; irq_o = 0. Repeat with INTR_CTRL_LEVEL_EN defined: a high src_i[2] keeps PENDING bit 2 set across a write-1-clear.
